fr_seq_checker: RTL and testbench

//  Read-side checker for the free-running counter test stream. Pops 32-bit words

---
 rtl/fr_seq_checker.sv | 123 ++++++++++++
 tb/tb_fr_seq_checker.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fr_seq_checker.sv
// -----------------------------------------------------------------------------
// fr_seq_checker
//
// Read-side checker for the free-running counter test stream. Pops words from
// a standard-mode (non-FWFT) FIFO and checks that every word equals the
// previous word plus one, modulo 2^WIDTH. It keeps a word count, a saturating
// error count and the most recent bad word. Host loopback tests can therefore
// be judged in hardware. The block sits between the host-to-FPGA FIFO read
// port and the status/LED logic.
//
// Parameters
//   WIDTH        data word width; sequence arithmetic wraps at 2^WIDTH
//   ERR_CNT_W    width of the saturating error counter
//   STOP_ON_ERR  1: stop reading at the first error; 0: resync and continue
//
// Ports
//   clk          single clock, all logic on the rising edge
//   rst          asynchronous, active-high reset
//   en           allows reads from the FIFO
//   clear        synchronous clear: counters to 0, sequence re-seeds
//   fifo_empty   FIFO empty flag
//   fifo_dout    FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_en   FIFO read strobe (combinational)
//   locked       first word seen, sequence being tracked
//   err_pulse    one-cycle pulse per mismatched word
//   err_count    mismatches since reset/clear, saturating at all-ones
//   word_count   words consumed since reset/clear, wraps
//   last_bad     most recent mismatched word
//   halted       reading stopped after an error (STOP_ON_ERR=1 only)
// -----------------------------------------------------------------------------
module fr_seq_checker #(
    parameter int WIDTH       = 32,
    parameter int ERR_CNT_W   = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [31:0]          word_count,
    output logic [WIDTH-1:0]     last_bad,
    output logic                 halted
);

    localparam logic [1:0] ST_SEED  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic STOP = (STOP_ON_ERR != 0);

    logic [1:0]       state;
    logic             rd_valid;   // fifo_dout holds a word popped last cycle
    logic [WIDTH-1:0] expected;
    logic             mismatch;
    logic             halt_now;

    assign halted   = (state == ST_HALT);
    assign mismatch = rd_valid && (state == ST_TRACK) && (fifo_dout != expected);

    // In stop mode, the word under test may be the one that halts the
    // checker. Any pop in that cycle is withheld. The next word then stays
    // in the FIFO for the host to inspect, and is not lost in a dead state.
    assign halt_now = STOP && mismatch;

    assign fifo_rd_en = en && !fifo_empty && !halted && !clear && !halt_now;

    // NOTE: registered state uses non-blocking assignments only, so every
    // branch below reads the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SEED;
            rd_valid   <= 1'b0;
            expected   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
            last_bad   <= '0;
        end else if (clear) begin
            // clear wins over a word arriving in the same cycle; that word
            // is dropped and the next one re-seeds the sequence
            state      <= ST_SEED;
            rd_valid   <= 1'b0;
            expected   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
            last_bad   <= '0;
        end else begin
            rd_valid  <= fifo_rd_en;
            err_pulse <= 1'b0;

            if (rd_valid && !halted) begin
                word_count <= word_count + 32'd1;
                // Seed, match and resync all track the word just seen. So
                // all-ones followed by zero is a correct sequence.
                expected   <= fifo_dout + WIDTH'(1);

                if (state == ST_SEED) begin
                    locked <= 1'b1;
                    state  <= ST_TRACK;
                end else if (mismatch) begin
                    err_pulse <= 1'b1;
                    last_bad  <= fifo_dout;
                    if (err_count != '1) begin
                        err_count <= err_count + ERR_CNT_W'(1);
                    end
                    if (STOP) begin
                        state <= ST_HALT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fr_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_fr_seq_checker
//
// The bench drives three checker instances with the same host stream:
//   u_free  default parameters (resync on error)
//   u_halt  STOP_ON_ERR = 1
//   u_sat   ERR_CNT_W = 4
// Each instance has its own FIFO, modelled as a queue. A stream-level
// reference model tracks the words popped, the expected next value and the
// counters. The model is checked against every instance on every cycle
// outside reset. Literal expectations pin the model at the end of each
// scenario.
// -----------------------------------------------------------------------------
module tb_fr_seq_checker;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic clear;

    logic        fifo_empty [N];
    logic [31:0] fifo_dout  [N];
    logic        fifo_rd_en [N];
    logic        locked     [N];
    logic        err_pulse  [N];
    logic        halted     [N];
    logic [15:0] err_count  [N];
    logic [3:0]  err_count_narrow;
    logic [31:0] word_count [N];
    logic [31:0] last_bad   [N];

    assign err_count[2] = {12'd0, err_count_narrow};

    always #5 clk = ~clk;

    fr_seq_checker u_free (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]), .fifo_rd_en(fifo_rd_en[0]),
        .locked(locked[0]), .err_pulse(err_pulse[0]), .err_count(err_count[0]),
        .word_count(word_count[0]), .last_bad(last_bad[0]), .halted(halted[0])
    );

    fr_seq_checker #(.STOP_ON_ERR(1)) u_halt (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]), .fifo_rd_en(fifo_rd_en[1]),
        .locked(locked[1]), .err_pulse(err_pulse[1]), .err_count(err_count[1]),
        .word_count(word_count[1]), .last_bad(last_bad[1]), .halted(halted[1])
    );

    fr_seq_checker #(.ERR_CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .fifo_empty(fifo_empty[2]), .fifo_dout(fifo_dout[2]), .fifo_rd_en(fifo_rd_en[2]),
        .locked(locked[2]), .err_pulse(err_pulse[2]), .err_count(err_count_narrow),
        .word_count(word_count[2]), .last_bad(last_bad[2]), .halted(halted[2])
    );

    // FIFO contents per instance
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];

    int n_checks      = 0;
    int n_errors      = 0;
    int pulse_cnt_sat = 0;

    // reference model, one entry per instance
    bit          m_pend   [N];   // a word left the FIFO at the last edge
    bit          m_seeded [N];
    bit          m_halt   [N];
    bit          m_pulse  [N];
    logic [31:0] m_exp    [N];
    logic [31:0] m_wcnt   [N];
    logic [31:0] m_last   [N];
    int unsigned m_ecnt   [N];

    int unsigned ecnt_max  [N] = '{32'd65535, 32'd65535, 32'd15};
    bit          stop_mode [N] = '{1'b0, 1'b1, 1'b0};

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s u%0d at %0t: got %h want %h", name, idx, $time, act, exp);
        end
    endtask

    task automatic refresh_empty();
        fifo_empty[0] = (q0.size() == 0);
        fifo_empty[1] = (q1.size() == 0);
        fifo_empty[2] = (q2.size() == 0);
    endtask

    task automatic push(input logic [31:0] w);
        q0.push_back(w);
        q1.push_back(w);
        q2.push_back(w);
        refresh_empty();
    endtask

    task automatic flush();
        q0.delete();
        q1.delete();
        q2.delete();
        refresh_empty();
    endtask

    // One clock: the read strobe is sampled mid-cycle, and the FIFO pops just
    // after the edge, like a standard-mode FIFO.
    task automatic tick();
        bit pop [N];
        @(negedge clk);
        for (int i = 0; i < N; i++) pop[i] = fifo_rd_en[i];
        @(posedge clk);
        #1;
        if (pop[0] && q0.size() > 0) fifo_dout[0] = q0.pop_front();
        if (pop[1] && q1.size() > 0) fifo_dout[1] = q1.pop_front();
        if (pop[2] && q2.size() > 0) fifo_dout[2] = q2.pop_front();
        refresh_empty();
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i]   = 1'b0;
            m_seeded[i] = 1'b0;
            m_halt[i]   = 1'b0;
            m_pulse[i]  = 1'b0;
            m_exp[i]    = '0;
            m_wcnt[i]   = '0;
            m_last[i]   = '0;
            m_ecnt[i]   = 0;
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
            end else begin
                for (int i = 0; i < N; i++) begin
                    bit          bad_word;
                    bit          exp_rd;
                    logic [31:0] d;
                    d        = fifo_dout[i];
                    bad_word = m_pend[i] && m_seeded[i] && (d != m_exp[i]);
                    exp_rd   = en && !fifo_empty[i] && !clear && !m_halt[i]
                               && !(stop_mode[i] && bad_word);

                    check("rd_en",      i, fifo_rd_en[i], exp_rd);
                    check("locked",     i, locked[i],     m_seeded[i]);
                    check("err_pulse",  i, err_pulse[i],  m_pulse[i]);
                    check("halted",     i, halted[i],     m_halt[i]);
                    check("err_count",  i, err_count[i],  m_ecnt[i]);
                    check("word_count", i, word_count[i], m_wcnt[i]);
                    check("last_bad",   i, last_bad[i],   m_last[i]);
                    if (i == 2 && err_pulse[2]) pulse_cnt_sat++;

                    if (clear) begin
                        m_pend[i]   = 1'b0;
                        m_seeded[i] = 1'b0;
                        m_halt[i]   = 1'b0;
                        m_pulse[i]  = 1'b0;
                        m_wcnt[i]   = '0;
                        m_last[i]   = '0;
                        m_ecnt[i]   = 0;
                    end else begin
                        m_pulse[i] = 1'b0;
                        if (m_pend[i]) begin
                            m_wcnt[i] = m_wcnt[i] + 1;
                            if (!m_seeded[i]) begin
                                m_seeded[i] = 1'b1;
                            end else if (bad_word) begin
                                m_pulse[i] = 1'b1;
                                m_last[i]  = d;
                                if (m_ecnt[i] < ecnt_max[i]) m_ecnt[i]++;
                                if (stop_mode[i]) m_halt[i] = 1'b1;
                            end
                            m_exp[i] = d + 1;
                        end
                        m_pend[i] = exp_rd;
                    end
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_bound", 0, (n < budget), 1'b1);
        repeat (3) tick();
    endtask

    task automatic do_clear(input bit flush_fifos);
        if (flush_fifos) flush();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] vec [$];
        logic [31:0] w;
        logic [31:0] next_word;
        int          exp_errs;
        int          pc0;

        rst   = 1'b1;
        en    = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = 1'b1;
            fifo_dout[i]  = '0;
        end
        model_reset();
        fork
            compare_loop();
        join_none

        // reset state
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            check("rst_locked", i, locked[i], 1'b0);
            check("rst_wcnt",   i, word_count[i], 32'd0);
            check("rst_ecnt",   i, err_count[i], 32'd0);
            check("rst_halted", i, halted[i], 1'b0);
            check("rst_pulse",  i, err_pulse[i], 1'b0);
        end
        rst = 1'b0;
        tick();

        // 1: clean ramp 0..99 with bursty pushes
        do_clear(1'b1);
        en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            push(k);
            if ($urandom_range(0, 2) == 0) tick();
        end
        drain(2000);
        for (int i = 0; i < N; i++) begin
            check("t1_wcnt",   i, word_count[i], 32'd100);
            check("t1_ecnt",   i, err_count[i], 32'd0);
            check("t1_locked", i, locked[i], 1'b1);
        end

        // 2: one gap, 5 6 7 9 10
        do_clear(1'b1);
        vec = '{32'd5, 32'd6, 32'd7, 32'd9, 32'd10};
        foreach (vec[j]) push(vec[j]);
        drain(200);
        check("t2_ecnt",   0, err_count[0], 32'd1);
        check("t2_last",   0, last_bad[0], 32'd9);
        check("t2_wcnt",   0, word_count[0], 32'd5);
        check("t2_ecnt",   2, err_count[2], 32'd1);
        check("t2_halted", 1, halted[1], 1'b1);
        check("t2_wcnt",   1, word_count[1], 32'd4);
        check("t2_left",   1, q1.size(), 32'd1);

        // 3: wrap through all-ones is not an error
        do_clear(1'b1);
        vec = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
        foreach (vec[j]) push(vec[j]);
        drain(200);
        for (int i = 0; i < N; i++) begin
            check("t3_ecnt", i, err_count[i], 32'd0);
            check("t3_wcnt", i, word_count[i], 32'd4);
        end

        // 4: stop on error, then clear out of HALT
        do_clear(1'b1);
        vec = '{32'd1, 32'd2, 32'd4, 32'd5};
        foreach (vec[j]) push(vec[j]);
        drain(200);
        check("t4_halted", 1, halted[1], 1'b1);
        check("t4_ecnt",   1, err_count[1], 32'd1);
        check("t4_wcnt",   1, word_count[1], 32'd3);
        check("t4_left",   1, q1.size(), 32'd1);
        check("t4_wcnt",   0, word_count[0], 32'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_clr_halted", 1, halted[1], 1'b0);
        check("t4_clr_wcnt",   1, word_count[1], 32'd0);
        check("t4_clr_ecnt",   1, err_count[1], 32'd0);
        check("t4_clr_locked", 1, locked[1], 1'b0);
        repeat (4) tick();
        check("t4_reseed_wcnt",   1, word_count[1], 32'd1);
        check("t4_reseed_locked", 1, locked[1], 1'b1);
        check("t4_reseed_left",   1, q1.size(), 32'd0);

        // 5: many errors, narrow counter saturates but pulses continue
        do_clear(1'b1);
        pc0      = pulse_cnt_sat;
        exp_errs = 0;
        w        = $urandom;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                if ((k % 2 == 1) || ($urandom_range(0, 3) == 0)) begin
                    w = w + 2 + $urandom_range(0, 100);
                    exp_errs++;
                end else begin
                    w = w + 1;
                end
            end
            push(w);
            if ($urandom_range(0, 1) == 0) tick();
        end
        drain(500);
        check("t5_ecnt_sat", 2, err_count[2], 32'd15);
        check("t5_wcnt",     2, word_count[2], 32'd40);
        check("t5_ecnt",     0, err_count[0], exp_errs);
        check("t5_pulses",   2, pulse_cnt_sat - pc0, exp_errs);

        // randomized stream: en toggling, occasional gaps and clears
        do_clear(1'b1);
        next_word = $urandom;
        for (int k = 0; k < 1500; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 99) == 0);
            if (q0.size() < 32 && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 15) == 0) next_word = next_word + $urandom_range(2, 9);
                push(next_word);
                next_word = next_word + 1;
            end
            tick();
        end
        clear = 1'b0;
        en    = 1'b1;
        drain(4000);

        // 6a: reset in the middle of a burst
        do_clear(1'b1);
        en = 1'b1;
        for (int k = 0; k < 30; k++) push(32'd1000 + k);
        repeat (8) tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check("t6_rst_wcnt",   i, word_count[i], 32'd0);
            check("t6_rst_locked", i, locked[i], 1'b0);
            check("t6_rst_pulse",  i, err_pulse[i], 1'b0);
        end
        tick();
        tick();
        rst = 1'b0;
        drain(500);
        for (int i = 0; i < N; i++) begin
            check("t6_ecnt",   i, err_count[i], 32'd0);
            check("t6_locked", i, locked[i], 1'b1);
        end

        // 6b: clear during the cycle a popped word is valid drops that word
        do_clear(1'b1);
        en = 1'b0;
        vec = '{32'd100, 32'd101, 32'd102};
        foreach (vec[j]) push(vec[j]);
        tick();
        en = 1'b1;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drain(100);
        for (int i = 0; i < N; i++) begin
            check("t6_clr_wcnt", i, word_count[i], 32'd2);
            check("t6_clr_ecnt", i, err_count[i], 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
